// File: rtl/axi_pkg.sv
// Shared AXI3 constants, field widths and the slave FSM state types.
package axi_pkg;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic       {R_IDLE, R_BURST}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;
endpackage

// File: rtl/axi_sram_mem.sv
// Simple dual-port word array: one synchronous read port, one byte-enable write port.
module axi_sram_mem #(
    parameter int WORDS     = 65536,
    parameter     INIT_FILE = "",
    localparam int AW       = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_strb,
    input  logic [31:0]   wr_data
);
    logic [31:0] mem [WORDS];

    // Read-first: a read and write to the same word in one cycle returns the old data.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed SRAM; independent read/write FSMs, one transaction each.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          MEM_WORDS = 65536,
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
    parameter              INIT_FILE = ""
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [SIZE_W-1:0] arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [SIZE_W-1:0] awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);
    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;

    logic unused_in;
    assign unused_in = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot};

    function automatic logic [AW-1:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    // WRAP and reserved bursts are rejected outright; otherwise decode per beat.
    function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [1:0] burst);
        logic [31:0] off;
        off = a - BASE_ADDR;
        if (burst[1])              return RESP_SLVERR;
        if ({1'b0, off} >= SPAN)   return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + 32'd4 : a;
    endfunction

    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [31:0]   mem_rd_data;

    axi_sram_mem #(.WORDS(MEM_WORDS), .INIT_FILE(INIT_FILE)) u_mem (
        .clk(aclk), .rd_en(mem_rd_en), .rd_addr(mem_rd_addr), .rd_data(mem_rd_data),
        .wr_en(mem_wr_en), .wr_addr(mem_wr_addr), .wr_strb(wstrb), .wr_data(wdata)
    );

    // Read channel
    r_state_t         r_state;
    logic [LEN_W-1:0] r_len, r_cnt;
    logic [1:0]       r_burst;
    logic [31:0]      r_addr, r_naddr;
    logic             ar_fire, r_fire, r_adv;

    assign ar_fire     = arvalid && arready;
    assign r_fire      = rvalid && rready;
    assign r_adv       = r_fire && (r_cnt != r_len);
    assign r_naddr     = next_addr(r_addr, r_burst);
    assign mem_rd_en   = ar_fire || r_adv;
    assign mem_rd_addr = ar_fire ? widx(araddr) : widx(r_naddr);
    // The array output only moves on a new beat, so rdata holds through a stall.
    assign rdata       = (rvalid && rresp == RESP_OKAY) ? mem_rd_data : 32'd0;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rresp   <= RESP_OKAY;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= BURST_FIXED;
            r_addr  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_fire) begin
                    r_state <= R_BURST;
                    arready <= 1'b0;
                    rvalid  <= 1'b1;
                    rid     <= arid;
                    r_len   <= arlen;
                    r_burst <= arburst;
                    r_addr  <= araddr;
                    r_cnt   <= '0;
                    rlast   <= (arlen == '0);
                    rresp   <= beat_resp(araddr, arburst);
                end
                R_BURST: if (r_fire) begin
                    if (r_cnt == r_len) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= r_naddr;
                        rlast  <= (r_cnt + 8'd1 == r_len);
                        rresp  <= beat_resp(r_naddr, r_burst);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write channel
    w_state_t         w_state;
    logic [ID_W-1:0]  w_id;
    logic [LEN_W-1:0] w_len, w_cnt;
    logic [1:0]       w_burst, w_beat_resp;
    logic [31:0]      w_addr;
    logic             w_err, w_dec, aw_fire, w_fire, w_last_beat, beat_err, beat_dec;

    assign aw_fire     = awvalid && awready;
    assign w_fire      = wvalid && wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_resp = beat_resp(w_addr, w_burst);
    assign beat_dec    = (w_beat_resp == RESP_DECERR);
    // Decode errors are tracked apart so DECERR can win when it is the only fault.
    assign beat_err    = (wid != w_id) || (wlast != w_last_beat) || (w_beat_resp == RESP_SLVERR);
    assign mem_wr_en   = w_fire && (w_beat_resp == RESP_OKAY);
    assign mem_wr_addr = widx(w_addr);

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_FIXED;
            w_addr  <= '0;
            w_err   <= 1'b0;
            w_dec   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_fire) begin
                    w_state <= W_DATA;
                    awready <= 1'b0;
                    wready  <= 1'b1;
                    w_id    <= awid;
                    w_len   <= awlen;
                    w_burst <= awburst;
                    w_addr  <= awaddr;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_dec   <= 1'b0;
                end
                W_DATA: if (w_fire) begin
                    w_err <= w_err || beat_err;
                    w_dec <= w_dec || beat_dec;
                    if (w_last_beat) begin
                        w_state <= W_RESP;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bid     <= w_id;
                        bresp   <= (w_err || beat_err) ? RESP_SLVERR :
                                   (w_dec || beat_dec) ? RESP_DECERR : RESP_OKAY;
                    end else begin
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= next_addr(w_addr, w_burst);
                    end
                end
                W_RESP: if (bready) begin
                    w_state <= W_IDLE;
                    bvalid  <= 1'b0;
                    awready <= 1'b1;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed table, corner sequences, random traffic vs a word-array model.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int          MW   = 1024;
    localparam logic [31:0] BASE = 32'h1C00_0000;
    localparam logic [31:0] TOP  = BASE + 32'(MW * 4);

    logic aclk = 1'b0, areset = 1'b1;
    logic [3:0] arid = '0, awid = '0, wid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic [7:0] arlen = '0, awlen = '0;
    logic [2:0] arsize = 3'b010, awsize = 3'b010, arprot = '0, awprot = '0;
    logic [1:0] arburst = '0, awburst = '0, arlock = '0, awlock = '0, rresp, bresp;
    logic [3:0] arcache = '0, awcache = '0, wstrb = '0;
    logic arvalid = 0, rready = 0, awvalid = 0, wlast = 0, wvalid = 0, bready = 0;
    logic arready, rlast, rvalid, awready, wready, bvalid;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int errs = 0, checks = 0;
    logic [31:0] ref_mem [MW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    function automatic logic [1:0] m_resp(input logic [31:0] a, input logic [1:0] burst);
        if (burst >= 2'd2)         return RESP_SLVERR;
        if (a < BASE || a >= TOP)  return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == BURST_INCR) ? a + 32'(4 * i) : a;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [31:0] dbase, input logic [3:0] strb,
                            input int wlast_at, input logic [3:0] wid_x, output logic [1:0] got);
        logic [31:0] a, d;
        logic [1:0]  r, exp;
        logic        err = 1'b0, dec = 1'b0;
        int          t;
        for (int i = 0; i <= len; i++) begin
            a = m_addr(addr, burst, i);
            r = m_resp(a, burst);
            d = dbase + 32'(i);
            if (r == RESP_SLVERR) err = 1'b1;
            if (r == RESP_DECERR) dec = 1'b1;
            if ((i == wlast_at) != (i == len) || wid_x != 4'd0) err = 1'b1;
            if (r == RESP_OKAY)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
        end
        exp = err ? RESP_SLVERR : (dec ? RESP_DECERR : RESP_OKAY);

        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin tick(); t++; end
        chk("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wid = id ^ wid_x; wdata = dbase + 32'(i); wstrb = strb; wlast = (i == wlast_at);
            t = 0;
            while (!wready && t < 50) begin tick(); t++; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin tick(); t++; end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, exp);
        chk("bid", bid, id);
        got = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [3:0] rpat, input int abort_at,
                           output logic [1:0] r0, output logic [31:0] d0);
        logic [31:0] a, ed, hd;
        logic [1:0]  er, hr;
        logic [3:0]  hid;
        logic        hl, stall = 1'b0;
        int          n = 0, k = 0, t = 0;
        r0 = 2'bxx; d0 = 'x;
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1; rready = 1'b0;
        while (!arready && t < 50) begin tick(); t++; end
        tick();
        arvalid = 1'b0;
        chk("rvalid_latency", rvalid, 1);
        t = 0;
        while (n <= len && t < 2000) begin
            if (stall) begin
                chk("hold_rdata", rdata, hd);
                chk("hold_rlast", rlast, hl);
                chk("hold_rid", rid, hid);
                chk("hold_rresp", rresp, hr);
            end
            if (abort_at > 0 && n == abort_at) begin
                rready = 1'b0; areset = 1'b1;
                tick();
                areset = 1'b0;
                chk("abort_rvalid", rvalid, 0);
                chk("abort_arready", arready, 1);
                return;
            end
            rready = rpat[k % 4];
            k++;
            if (rvalid && rready) begin
                a  = m_addr(addr, burst, n);
                er = m_resp(a, burst);
                ed = (er == RESP_OKAY) ? ref_mem[m_idx(a)] : 32'd0;
                chk($sformatf("rdata_b%0d", n), rdata, ed);
                chk($sformatf("rresp_b%0d", n), rresp, er);
                chk($sformatf("rlast_b%0d", n), rlast, n == len);
                chk("rid", rid, id);
                if (n == 0) begin r0 = rresp; d0 = rdata; end
                n++;
            end
            stall = rvalid && !rready;
            hd = rdata; hl = rlast; hid = rid; hr = rresp;
            tick();
            t++;
        end
        rready = 1'b0;
        chk("beat_count", n, len + 1);
        chk("read_done_idle", {rvalid, arready}, 2'b01);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        int          len;
        logic [1:0]  burst;
        logic [31:0] dbase;
        logic [3:0]  strb;
        int          wlast_at;
        logic [3:0]  wid_x;
        logic [3:0]  rpat;
        logic [1:0]  exp_resp;
        bit          chk_d;
        logic [31:0] exp_d0;
    } vec_t;

    function automatic vec_t vw(input logic [3:0] id, input logic [31:0] addr, input int len,
                                input logic [1:0] burst, input logic [31:0] dbase, input logic [3:0] strb,
                                input int wlast_at, input logic [3:0] wid_x, input logic [1:0] exp);
        return '{1'b1, id, addr, len, burst, dbase, strb, wlast_at, wid_x, 4'hF, exp, 1'b0, 32'd0};
    endfunction

    function automatic vec_t vr(input logic [3:0] id, input logic [31:0] addr, input int len,
                                input logic [1:0] burst, input logic [3:0] rpat, input logic [1:0] exp,
                                input bit chk_d, input logic [31:0] d0);
        return '{1'b0, id, addr, len, burst, 32'd0, 4'h0, 0, 4'h0, rpat, exp, chk_d, d0};
    endfunction

    vec_t        vt[$];
    logic [1:0]  got, r0;
    logic [31:0] d0, a;
    int          len, wl;
    logic [1:0]  burst;

    initial begin
        tick();
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rdata", rdata, 0);
        areset = 1'b0;
        tick();

        // Give every word a known value so the model matches from the start.
        for (int i = 0; i < MW / 256; i++)
            do_write(4'(i), BASE + 32'(i * 1024), 255, BURST_INCR, 32'(i * 256), 4'hF, 255, 4'h0, got);

        vt.push_back(vw(3,  BASE + 32'h10,  0, BURST_INCR,  32'hDEADBEEF, 4'hF, 0, 4'h0, RESP_OKAY));
        vt.push_back(vr(5,  BASE + 32'h10,  0, BURST_INCR,  4'hF, RESP_OKAY, 1, 32'hDEADBEEF));
        vt.push_back(vw(1,  BASE + 32'h100, 3, BURST_INCR,  32'd1, 4'hF, 3, 4'h0, RESP_OKAY));
        vt.push_back(vr(2,  BASE + 32'h100, 3, BURST_INCR,  4'hF, RESP_OKAY, 1, 32'd1));
        vt.push_back(vw(4,  BASE + 32'h200, 0, BURST_INCR,  32'h11223344, 4'hF, 0, 4'h0, RESP_OKAY));
        vt.push_back(vw(4,  BASE + 32'h200, 0, BURST_INCR,  32'hAABBCCDD, 4'b0101, 0, 4'h0, RESP_OKAY));
        vt.push_back(vr(6,  BASE + 32'h200, 0, BURST_INCR,  4'hF, RESP_OKAY, 1, 32'h11BB33DD));
        vt.push_back(vr(7,  BASE - 32'd4,   0, BURST_INCR,  4'hF, RESP_DECERR, 1, 32'd0));
        vt.push_back(vw(8,  BASE + 32'h100, 3, BURST_WRAP,  32'h55, 4'hF, 3, 4'h0, RESP_SLVERR));
        vt.push_back(vr(9,  BASE + 32'h100, 3, BURST_INCR,  4'hF, RESP_OKAY, 1, 32'd1));
        vt.push_back(vw(10, BASE + 32'h300, 3, BURST_INCR,  32'h20, 4'hF, 1, 4'h0, RESP_SLVERR));
        vt.push_back(vw(11, BASE + 32'h400, 7, BURST_INCR,  32'h100, 4'hF, 7, 4'h0, RESP_OKAY));
        vt.push_back(vr(12, BASE + 32'h400, 7, BURST_INCR,  4'b1001, RESP_OKAY, 1, 32'h100));
        vt.push_back(vw(13, BASE + 32'h500, 2, BURST_FIXED, 32'h70, 4'hF, 2, 4'h0, RESP_OKAY));
        vt.push_back(vr(13, BASE + 32'h500, 2, BURST_FIXED, 4'hF, RESP_OKAY, 1, 32'h72));
        vt.push_back(vr(14, TOP - 32'd8,    3, BURST_INCR,  4'b0111, RESP_OKAY, 0, 32'd0));
        vt.push_back(vw(15, BASE + 32'h600, 1, BURST_INCR,  32'd1, 4'hF, 1, 4'h1, RESP_SLVERR));
        vt.push_back(vw(0,  TOP - 32'd4,    1, BURST_INCR,  32'h99, 4'hF, 1, 4'h0, RESP_DECERR));
        vt.push_back(vr(1,  BASE + 32'h100, 1, 2'b11,       4'hF, RESP_SLVERR, 1, 32'd0));

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                do_write(vt[i].id, vt[i].addr, vt[i].len, vt[i].burst, vt[i].dbase, vt[i].strb,
                         vt[i].wlast_at, vt[i].wid_x, got);
                chk($sformatf("vec%0d_bresp", i), got, vt[i].exp_resp);
            end else begin
                do_read(vt[i].id, vt[i].addr, vt[i].len, vt[i].burst, vt[i].rpat, 0, r0, d0);
                chk($sformatf("vec%0d_rresp", i), r0, vt[i].exp_resp);
                if (vt[i].chk_d) chk($sformatf("vec%0d_rdata", i), d0, vt[i].exp_d0);
            end
        end

        // Reset during beat 3 of 8, then a fresh read of the same data.
        do_read(4'd3, BASE + 32'h400, 7, BURST_INCR, 4'hF, 3, r0, d0);
        tick();
        do_read(4'd4, BASE + 32'h400, 7, BURST_INCR, 4'hF, 0, r0, d0);
        chk("post_reset_resp", r0, RESP_OKAY);
        chk("post_reset_data", d0, 32'h100);

        // Same-cycle read and write of one word: the read sees the old value.
        a = BASE + 32'h800;
        awid = 4'd2; awaddr = a; awlen = 8'd0; awburst = BURST_INCR; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("rw_wready", wready, 1);
        chk("rw_arready", arready, 1);
        arid = 4'd6; araddr = a; arlen = 8'd0; arburst = BURST_INCR; arvalid = 1'b1;
        wid = 4'd2; wdata = 32'hC0FFEE00; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        chk("rw_rvalid", rvalid, 1);
        chk("rw_old_data", rdata, ref_mem[m_idx(a)]);
        chk("rw_bvalid", bvalid, 1);
        chk("rw_bresp", bresp, RESP_OKAY);
        ref_mem[m_idx(a)] = 32'hC0FFEE00;
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        do_read(4'd7, a, 0, BURST_INCR, 4'hF, 0, r0, d0);
        chk("rw_new_data", d0, 32'hC0FFEE00);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'(4 * $urandom_range(1, 4));
                1:       a = TOP - 32'(4 * $urandom_range(0, 3));
                default: a = BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
            endcase
            len   = int'($urandom_range(0, 15));
            burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                wl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : len;
                do_write(4'($urandom), a, len, burst, $urandom, 4'($urandom), wl, 4'h0, got);
            end else begin
                do_read(4'($urandom), a, len, burst, 4'($urandom) | 4'b0001, 0, r0, d0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
